// File: rtl/iq_lo_pkg.sv
// Shared types and elaboration-time helpers for the quadrature LO generator.
// The sine table is computed here so the ROM and any other user agree on the rounding.
package iq_lo_pkg;

    typedef enum logic {
        LO_DIR_POS = 1'b0,
        LO_DIR_NEG = 1'b1
    } lo_dir_t;

    localparam real LO_TWO_PI = 6.283185307179586;

    function automatic int lo_points(input int phase_bits);
        return 1 << phase_bits;
    endfunction

    function automatic int lo_amp(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    // Round half away from zero so the table stays symmetric about zero.
    function automatic int lo_sin_lut(input int idx, input int data_w, input int phase_bits);
        real x;
        x = real'(lo_amp(data_w)) * $sin(LO_TWO_PI * real'(idx) / real'(lo_points(phase_bits)));
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/iq_lo_lut.sv
// Combinational N-entry signed sine ROM; every entry is a constant fixed at elaboration.
module iq_lo_lut
    import iq_lo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PHASE_BITS = 4
) (
    input  logic        [PHASE_BITS-1:0] idx_i,
    output logic signed [DATA_W-1:0]     data_o
);

    localparam int N = lo_points(PHASE_BITS);

    logic signed [DATA_W-1:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam int V = lo_sin_lut(k, DATA_W, PHASE_BITS);
        assign rom[k] = V[DATA_W-1:0];
    end

    assign data_o = rom[idx_i];

endmodule

// File: rtl/iq_lo_gen.sv
// Quadrature LO: divider-paced phase accumulator with registered sin/cos samples
// and a valid strobe aligned with each new sample pair.
module iq_lo_gen
    import iq_lo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PHASE_BITS = 4,
    parameter int DIV_W      = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         en_i,
    input  logic        [DIV_W-1:0]      div_i,
    input  logic                         dir_i,
    input  logic                         phase_ld_i,
    input  logic        [PHASE_BITS-1:0] phase_ofs_i,
    output logic        [PHASE_BITS-1:0] phase_o,
    output logic signed [DATA_W-1:0]     sin_o,
    output logic signed [DATA_W-1:0]     cos_o,
    output logic                         valid_o
);

    localparam int                       AMP     = lo_amp(DATA_W);
    localparam logic signed [DATA_W-1:0] AMP_W   = DATA_W'(AMP);
    localparam logic [PHASE_BITS-1:0]    QUARTER = PHASE_BITS'(lo_points(PHASE_BITS) / 4);

    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic [PHASE_BITS-1:0]    phase_q, phase_d;
    logic [PHASE_BITS-1:0]    cos_idx;
    logic signed [DATA_W-1:0] sin_q, cos_q;
    logic signed [DATA_W-1:0] sin_lut, cos_lut;
    logic                     evt_q, evt_d;
    logic                     valid_q;
    logic                     tick;
    lo_dir_t                  dir;

    assign dir     = lo_dir_t'(dir_i);
    assign cos_idx = phase_q + QUARTER;

    // A load wins over a coincident tick and restarts the divider even while disabled.
    always_comb begin
        tick    = en_i && (cnt_q >= div_i);
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (phase_ld_i) begin
            phase_d = phase_ofs_i;
            cnt_d   = '0;
        end else begin
            if (en_i) begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
            end
            if (tick) begin
                phase_d = (dir == LO_DIR_NEG) ? phase_q - 1'b1 : phase_q + 1'b1;
            end
        end
        evt_d = tick | phase_ld_i;
    end

    iq_lo_lut #(
        .DATA_W     (DATA_W),
        .PHASE_BITS (PHASE_BITS)
    ) u_sin_lut (
        .idx_i  (phase_q),
        .data_o (sin_lut)
    );

    iq_lo_lut #(
        .DATA_W     (DATA_W),
        .PHASE_BITS (PHASE_BITS)
    ) u_cos_lut (
        .idx_i  (cos_idx),
        .data_o (cos_lut)
    );

    // The phase event passes through evt_q so valid_o lines up with the samples it describes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= '0;
            sin_q   <= '0;
            cos_q   <= AMP_W;
            evt_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sin_q   <= sin_lut;
            cos_q   <= cos_lut;
            evt_q   <= evt_d;
            valid_q <= evt_q;
        end
    end

    assign phase_o = phase_q;
    assign sin_o   = sin_q;
    assign cos_o   = cos_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_iq_lo_gen.sv
// Bench for iq_lo_gen: a cycle model feeds a scoreboard for the default build,
// plus directed checks on the default and legacy (2-bit, 4-point) builds.
module tb_iq_lo_gen;

    typedef struct packed {
        logic [3:0]        ph;
        logic signed [7:0] s;
        logic signed [7:0] c;
        logic              v;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    logic              en, dir, ld;
    logic [7:0]        div;
    logic [3:0]        ofs;
    logic [3:0]        phase;
    logic signed [7:0] sinV, cosV;
    logic              valid;

    logic              enL, dirL, ldL;
    logic [7:0]        divL;
    logic [1:0]        ofsL;
    logic [1:0]        phaseL;
    logic signed [1:0] sinL, cosL;
    logic              validL;

    int nTests = 0;
    int nFail  = 0;

    logic signed [7:0] refLut [16];
    exp_t              sbq [$];

    logic [7:0] mCnt;
    logic [3:0] mPhase;
    logic       mEvt;
    logic       mTick;
    logic [3:0] mPhaseNext;
    logic [7:0] mCntNext;

    always #5 clk = ~clk;

    iq_lo_gen u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .en_i        (en),
        .div_i       (div),
        .dir_i       (dir),
        .phase_ld_i  (ld),
        .phase_ofs_i (ofs),
        .phase_o     (phase),
        .sin_o       (sinV),
        .cos_o       (cosV),
        .valid_o     (valid)
    );

    iq_lo_gen #(
        .DATA_W     (2),
        .PHASE_BITS (2),
        .DIV_W      (8)
    ) u_leg (
        .clk         (clk),
        .resetn      (resetn),
        .en_i        (enL),
        .div_i       (divL),
        .dir_i       (dirL),
        .phase_ld_i  (ldL),
        .phase_ofs_i (ofsL),
        .phase_o     (phaseL),
        .sin_o       (sinL),
        .cos_o       (cosL),
        .valid_o     (validL)
    );

    function automatic int refSin(input int k);
        real x;
        x = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 16.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(0.5 - x));
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] want);
        nTests++;
        assert (got === want) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] d, input logic r,
                                 input logic l, input logic [3:0] o);
        @(negedge clk);
        en  = e;
        div = d;
        dir = r;
        ld  = l;
        ofs = o;
    endtask

    task automatic waitSample();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of the default build, one expected entry per clock edge.
    assign mTick      = en && (mCnt >= div);
    assign mPhaseNext = ld ? ofs : (mTick ? (dir ? mPhase - 4'd1 : mPhase + 4'd1) : mPhase);
    assign mCntNext   = (ld || mTick) ? 8'd0 : (en ? mCnt + 8'd1 : mCnt);

    always @(posedge clk) begin
        if (!resetn) begin
            mCnt   <= 8'd0;
            mPhase <= 4'd0;
            mEvt   <= 1'b0;
            sbq.push_back('{ph: 4'd0, s: 8'sd0, c: 8'sd127, v: 1'b0});
        end else begin
            mCnt   <= mCntNext;
            mPhase <= mPhaseNext;
            mEvt   <= mTick | ld;
            sbq.push_back('{ph: mPhaseNext, s: refLut[mPhase],
                            c: refLut[4'(mPhase + 4'd4)], v: mEvt});
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        checkOutput("sb_nonempty", 32'(sbq.size() != 0), 32'sd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checkOutput("sb_phase", 32'(phase), 32'(e.ph));
            checkOutput("sb_sin", 32'(sinV), 32'(e.s));
            checkOutput("sb_cos", 32'(cosV), 32'(e.c));
            checkOutput("sb_valid", 32'(valid), 32'(e.v));
        end
    end

    initial begin
        logic signed [1:0] legSin [5];
        logic signed [1:0] legCos [5];
        legSin = '{2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0};
        legCos = '{2'sd1, 2'sd0, -2'sd1, 2'sd0, 2'sd1};
        for (int k = 0; k < 16; k++) refLut[k] = 8'(refSin(k));

        en = 1'b1; div = 8'd4; dir = 1'b0; ld = 1'b0; ofs = 4'd0;
        enL = 1'b1; divL = 8'd4; dirL = 1'b0; ldL = 1'b0; ofsL = 2'd0;

        // Reset values on both builds
        waitSample();
        waitSample();
        checkOutput("rst_phase", 32'(phase), 32'sd0);
        checkOutput("rst_sin", 32'(sinV), 32'sd0);
        checkOutput("rst_cos", 32'(cosV), 32'sd127);
        checkOutput("rst_valid", 32'(valid), 32'sd0);
        checkOutput("leg_rst_sin", 32'(sinL), 32'sd0);
        checkOutput("leg_rst_cos", 32'(cosL), 32'sd1);

        // Legacy sequence: each pair held 5 clocks, valid on each change
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            waitSample();
            checkOutput("leg_sin", 32'(sinL), 32'(legSin[(k - 1) / 5]));
            checkOutput("leg_cos", 32'(cosL), 32'(legCos[(k - 1) / 5]));
            checkOutput("leg_valid", 32'(validL), 32'((k > 5) && ((k - 1) % 5 == 0)));
        end

        // div=0 forward: phase steps every clock and wraps 15 -> 0
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b1, 4'd0);
        waitSample();
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            waitSample();
            checkOutput("fwd_phase", 32'(phase), 32'(k % 16));
            if (k == 3) begin
                checkOutput("fwd_sin_p2", 32'(sinV), 32'sd90);
                checkOutput("fwd_cos_p2", 32'(cosV), 32'sd90);
            end
            if (k == 5) begin
                checkOutput("fwd_sin_p4", 32'(sinV), 32'sd127);
                checkOutput("fwd_cos_p4", 32'(cosV), 32'sd0);
            end
        end

        // Reverse direction from reset, then flip direction mid-run
        @(negedge clk);
        #2;
        resetn = 1'b0;
        dir = 1'b1;
        #1;
        checkOutput("arst1_phase", 32'(phase), 32'sd0);
        checkOutput("arst1_cos", 32'(cosV), 32'sd127);
        waitSample();
        @(negedge clk);
        resetn = 1'b1;
        waitSample();
        checkOutput("rev_phase15", 32'(phase), 32'sd15);
        waitSample();
        checkOutput("rev_sin", 32'(sinV), -32'sd49);
        checkOutput("rev_cos", 32'(cosV), 32'sd117);
        checkOutput("rev_phase14", 32'(phase), 32'sd14);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 4'd0);
        waitSample();
        checkOutput("flip_phase", 32'(phase), 32'sd15);

        // Freeze with cnt=2 and div=3, then resume
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b1, 4'd5);
        waitSample();
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 4'd5);
        waitSample();
        waitSample();
        applyStimulus(1'b0, 8'd3, 1'b0, 1'b0, 4'd5);
        for (int k = 0; k < 7; k++) begin
            waitSample();
            checkOutput("frz_phase", 32'(phase), 32'sd5);
            checkOutput("frz_sin", 32'(sinV), 32'sd117);
            checkOutput("frz_cos", 32'(cosV), -32'sd49);
            checkOutput("frz_valid", 32'(valid), 32'sd0);
        end
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 4'd5);
        waitSample();
        checkOutput("res_phase_hold", 32'(phase), 32'sd5);
        waitSample();
        checkOutput("res_phase_step", 32'(phase), 32'sd6);
        waitSample();
        checkOutput("res_valid", 32'(valid), 32'sd1);
        checkOutput("res_sin", 32'(sinV), 32'sd90);

        // Load coincident with a tick wins; reloading the same phase still strobes
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 4'd0);
        waitSample();
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b1, 4'd8);
        waitSample();
        checkOutput("ld_phase", 32'(phase), 32'sd8);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 4'd8);
        waitSample();
        checkOutput("ld_sin", 32'(sinV), 32'sd0);
        checkOutput("ld_cos", 32'(cosV), -32'sd127);
        checkOutput("ld_valid", 32'(valid), 32'sd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 4'd8);
        waitSample();
        checkOutput("same_ld_phase", 32'(phase), 32'sd8);
        checkOutput("same_ld_novalid", 32'(valid), 32'sd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 4'd8);
        waitSample();
        checkOutput("same_ld_valid", 32'(valid), 32'sd1);

        // Asynchronous reset mid-period, then first tick div+1 clocks after release
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, 4'd0);
        waitSample();
        waitSample();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_phase", 32'(phase), 32'sd0);
        checkOutput("arst_sin", 32'(sinV), 32'sd0);
        checkOutput("arst_cos", 32'(cosV), 32'sd127);
        checkOutput("arst_valid", 32'(valid), 32'sd0);
        waitSample();
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            waitSample();
            checkOutput("post_rst_phase", 32'(phase), 32'((k == 5) ? 1 : 0));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/iq_lo_gen.md
Name: iq_lo_gen

Overview:
- Parametrised quadrature local-oscillator generator for the IQ demodulator. Successor to the fixed 4-point ternary sine/cosine FSM.
- Generates signed sin/cos samples from an N-point table, N = 2**PHASE_BITS.
- Features: programmable step divider, enable, rotation direction, synchronous phase load, and a sample-valid strobe for the downstream mixers.

Parameters:
- DATA_W, 8: signed sample width; amplitude AMP = 2**(DATA_W-1)-1.
- PHASE_BITS, 4: log2 of points per LO period; must be >= 2.
- DIV_W, 8: width of the divider ratio input.

Ports:
- clk  in  1  main clock.
- resetn  in  1  asynchronous active-low reset.
- en_i  in  1  1 = divider counts and phase advances; 0 = everything frozen.
- div_i  in  DIV_W  phase advances once every div_i+1 enabled clocks.
- dir_i  in  1  0 = phase +1 per step; 1 = phase -1 per step (negative frequency).
- phase_ld_i  in  1  synchronous load of phase_ofs_i into the phase register.
- phase_ofs_i  in  PHASE_BITS  phase value loaded on phase_ld_i.
- phase_o  out  PHASE_BITS  current phase register.
- sin_o  out  DATA_W  signed sine sample, registered.
- cos_o  out  DATA_W  signed cosine sample, registered.
- valid_o  out  1  one-cycle pulse, high in the cycle a new sin_o/cos_o is presented.

Behaviour:
- Table contents:
  - LUT[k] = round(AMP * sin(2*pi*k/N)), rounding half away from zero, computed at elaboration.
  - sin value = LUT[phase]; cos value = LUT[(phase + N/4) mod N].
- Reset (resetn=0, asynchronous):
  - cnt=0, phase_o=0, sin_o=0, cos_o=AMP, valid_o=0.
- Divider counter cnt (DIV_W bits):
  - en_i=1 and cnt >= div_i: cnt<=0 and tick=1. The >= compare handles div_i being lowered below cnt mid-count.
  - en_i=1 otherwise: cnt<=cnt+1, tick=0.
  - en_i=0: cnt holds, tick=0.
- Phase update:
  - phase_ld_i=1 (highest priority after reset): phase<=phase_ofs_i, cnt<=0. Any tick in the same cycle is discarded. This applies regardless of en_i.
  - else tick=1: phase <= phase+1 (dir_i=0) or phase-1 (dir_i=1), modulo N. Wrap N-1→0 and 0→N-1 with no extra cycle.
  - else: phase holds.
  - dir_i is sampled only on tick cycles; changing it never costs a cycle.
- Output stage:
  - Every cycle, sin_o<=LUT[phase_o] and cos_o<=LUT[phase_o+N/4]. Latency is 1 clock from a phase_o change to the samples.
  - valid_o is the tick/load event delayed 1 clock, so it is coincident with the new samples.
  - A load to the same phase value still pulses valid_o.
- Example rate: div_i=4 gives one phase step every 5 clocks, i.e. LO period 5*N clocks.
- No combinational path from any input to any output.
- Legacy compatibility: DATA_W=2, PHASE_BITS=2, div_i=4 reproduces the previous LO exactly.
  - After reset: sin/cos = (0,1).
  - Then (1,0), (0,-1), (-1,0), (0,1), ... each held 5 clocks, clockwise rotation.

Decomposition:
- Package iq_lo_pkg:
  - function lo_sin_lut(idx, DATA_W, PHASE_BITS) returning the rounded signed value.
  - localparam helpers N and AMP.
  - typedef lo_dir_t {LO_DIR_POS, LO_DIR_NEG}.
- One sub-module, iq_lo_lut: purely combinational N-entry ROM, instantiated twice (sin index, cos index) and built from the package function.
- Divider, phase register and output registers stay in iq_lo_gen.

Test Plan:
- Legacy config (DATA_W=2, PHASE_BITS=2, en=1, div=4, dir=0), release reset → sin_o sequence 0,1,0,-1,0 and cos_o 1,0,-1,0,1. Each value held exactly 5 clocks; valid_o high one cycle per change.
- Defaults, div=0, dir=0 → phase_o increments every clock, 15→0 wrap. At phase 2: sin_o=90, cos_o=90. At phase 4: sin_o=127, cos_o=0. Samples lag phase_o by 1 clock.
- Defaults, div=0, dir=1 from reset → phase_o=15, then sin_o=-49, cos_o=117. Toggling dir_i mid-run reverses direction on the next tick with no hold cycle.
- en_i=0 for 7 cycles mid-count (div=3, cnt=2) → cnt, phase_o, sin_o, cos_o frozen and valid_o=0. After re-enable, the next tick follows exactly 2 more clocks.
- phase_ld_i=1 with phase_ofs_i=8 in the same cycle as a tick → phase_o=8 (not 9), cnt=0. Next cycle: sin_o=0, cos_o=-127, valid_o=1.
- Assert resetn low asynchronously mid-period (no clock edge) → outputs return immediately to phase_o=0, sin_o=0, cos_o=127, valid_o=0. After release, the first tick occurs div_i+1 clocks later.
